vga_scan_gen: RTL and testbench
===============================

Name: vga_scan_gen

Overview:
Parametrised VGA timing generator and frame-buffer scan-out engine; the next generation of the fixed 640x480 VGA block.
- Generates hsync/vsync/de from a programmable timing set.
- Reads an IMG_W x IMG_H image from frame memory with integer pixel replication (SCALE) inside a positioned window; the rest of the active area is a border colour.
- Compensates arbitrary read latency so sync, de and colour leave aligned.
- Sits between the frame buffer read port and the DAC/VGA pins.

Parameters:
CW, 4, bits per colour channel
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level
IMG_W, 320, stored image width (pixels)
IMG_H, 240, stored image height (lines)
SCALE, 2, horizontal and vertical replication factor, >=1
WIN_X, 0, first active column of the image window
WIN_Y, 0, first active line of the image window
RD_LAT, 1, frame-memory read latency (clocks, >=1)
ADDR_W, 17, read address width, >= clog2(IMG_W*IMG_H)
BORDER, 0, 3*CW-bit colour for active pixels outside the window

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active high
frame_sync  in  1  restarts the frame at h=0, v=0
rd_en  out  1  frame-memory read strobe
rd_addr  out  ADDR_W  frame-memory read address
rd_data  in  3*CW  read data, valid RD_LAT clocks after rd_en; red [CW-1:0], grn [2CW-1:CW], blu [3CW-1:2CW]
red  out  CW  red output
grn  out  CW  green output
blu  out  CW  blue output
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  active-video enable
frame_start  out  1  one-clock pulse on the first pixel (h=0, v=0) at the output

Behaviour:
- Sync and reset are sampled on the rising edge of clk; rst has priority over frame_sync.
- Reset values: counters 0, rd_en 0, rd_addr 0, de 0, red/grn/blu 0, hsync = ~HS_POL, vsync = ~VS_POL, frame_start 0, alignment pipeline cleared.
- Counters: H_TOT = sum of the four H parameters; V_TOT = sum of the four V parameters.
  - h counts 0..H_TOT-1 and wraps.
  - v increments on h wrap and counts 0..V_TOT-1.
  - Active region first: h < H_ACTIVE and v < V_ACTIVE.
- Sync: hsync = HS_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vsync = VS_POL for the whole lines where V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Window: WIN_X <= h < WIN_X+IMG_W*SCALE and WIN_Y <= v < WIN_Y+IMG_H*SCALE.
  - Parameters must keep the window inside the active area.
  - rd_en = 1 exactly on window pixels; rd_en and rd_addr are registered, same cycle as the counter state.
- Address: rd_addr = row*IMG_W + col, with col = (h-WIN_X)/SCALE and row = (v-WIN_Y)/SCALE.
  - Implement incrementally with sub-counters; no divider or multiplier.
  - At window line end: if the sub-line count < SCALE-1, rd_addr rewinds to the line base; otherwise it advances to base+IMG_W.
  - rd_addr returns to 0 at frame start.
- Alignment:
  - hsync, vsync, de, frame_start and the window flag are delayed by RD_LAT+1 clocks from the counter state.
  - Colour is registered from rd_data when the delayed window flag is set; BORDER when de is set and outside the window; 0 when de is 0.
  - Total latency from counter state to all outputs is RD_LAT+1, identical for every output.
- frame_sync: on the next clock h=0, v=0, sub-counters 0, rd_addr 0.
  - The pipeline is not flushed: in-flight outputs drain, and outputs reflect the new position RD_LAT+1 clocks later.
  - frame_sync at h=H_TOT-1, v=V_TOT-1 is indistinguishable from a natural wrap.
  - frame_sync held high keeps the counters at 0.
- SCALE=1: no repeats; the address increments on every window pixel.
- Mid-line rst: all outputs take reset values on the next edge and stay there while rst is high. Counting restarts at h=0, v=0 on the first clock after release.

Test Plan:
- Defaults, free run 2 frames -> frame length 420000 clocks; hsync low 96 clocks starting output-cycle 656+2 of each line; vsync low on lines 490-491 only; de high 640 clocks per line on lines 0-479; frame_start once per frame.
- Defaults, log rd_addr per rd_en -> line 0: 0,0,1,1,...,319,319; line 1 repeats 0..319; line 2 starts 320; last read 76799 on line 479; then 0 at the next frame.
- RD_LAT=3, memory model returns data=addr[11:0] -> {blu,grn,red} equals the model's value for every de pixel, with no skew against de/hsync (latency 4).
- WIN_X=100, WIN_Y=20, IMG_W=200, IMG_H=100, SCALE=1, BORDER=12'h00F -> on lines 20-119: red=F for h 0-99 and 300-639, image data for h 100-299; rd_en count per frame 20000; border-only on other active lines.
- frame_sync pulse at h=300, v=200 -> next clock h=0, v=0, rd_addr=0; frame_start pulse 2 clocks later; the old line's tail drains; the next frame timing is exact.
- rst asserted at h=400, v=100 for 5 clocks, together with frame_sync -> outputs at reset values during rst; after release the first frame_start occurs 2 clocks after counting resumes; the rd_addr sequence restarts at 0.

Source files
------------

// File: rtl/vga_scan_gen.sv
// VGA timing generator with windowed, pixel-replicated frame-buffer scan-out.
// Sync, de and colour leave through one alignment pipeline of RD_LAT+1 clocks.
module vga_scan_gen #(
  parameter int              CW       = 4,
  parameter int              H_ACTIVE = 640,
  parameter int              H_FP     = 16,
  parameter int              H_SYNC   = 96,
  parameter int              H_BP     = 48,
  parameter int              V_ACTIVE = 480,
  parameter int              V_FP     = 10,
  parameter int              V_SYNC   = 2,
  parameter int              V_BP     = 33,
  parameter bit              HS_POL   = 1'b0,
  parameter bit              VS_POL   = 1'b0,
  parameter int              IMG_W    = 320,
  parameter int              IMG_H    = 240,
  parameter int              SCALE    = 2,
  parameter int              WIN_X    = 0,
  parameter int              WIN_Y    = 0,
  parameter int              RD_LAT   = 1,
  parameter int              ADDR_W   = 17,
  parameter logic [3*CW-1:0] BORDER   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_sync,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [3*CW-1:0]   rd_data,
  output logic [CW-1:0]     red,
  output logic [CW-1:0]     grn,
  output logic [CW-1:0]     blu,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int PD    = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX0     = HW'(WIN_X);
  localparam logic [HW-1:0] WX1     = HW'(WIN_X + IMG_W * SCALE);
  localparam logic [HW-1:0] WX_LAST = HW'(WIN_X + IMG_W * SCALE - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY0     = VW'(WIN_Y);
  localparam logic [VW-1:0] WY1     = VW'(WIN_Y + IMG_H * SCALE);
  localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  logic [HW-1:0]     h, h_nxt;
  logic [VW-1:0]     v, v_nxt;
  logic              run, restart;
  logic              xin, yin, xin_nxt, yin_nxt;
  logic [SW-1:0]     sub_x, sub_y;
  logic [ADDR_W-1:0] line_base;
  logic              hs_raw, vs_raw, de_raw, fs_raw;
  logic [PD-1:0]     hs_p, vs_p, de_p, fs_p, wn_p;
  logic [3*CW-1:0]   rgb;

  // run is low for the first clock after reset so that edge loads h=0, v=0
  always_comb begin
    restart = !run || frame_sync || (h == H_LAST && v == V_LAST);
    h_nxt   = h;
    v_nxt   = v;
    if (restart) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = v + 1'b1;
    end else begin
      h_nxt = h + 1'b1;
    end

    xin_nxt = xin;
    if (h_nxt == WX0)                 xin_nxt = 1'b1;
    else if (h_nxt == WX1 || restart) xin_nxt = 1'b0;
    yin_nxt = yin;
    if (v_nxt == WY0)                 yin_nxt = 1'b1;
    else if (v_nxt == WY1 || restart) yin_nxt = 1'b0;

    hs_raw = (run && h >= HS_BEG && h < HS_END) ? HS_POL : ~HS_POL;
    vs_raw = (run && v >= VS_BEG && v < VS_END) ? VS_POL : ~VS_POL;
    de_raw = run && (h < H_ACT) && (v < V_ACT);
    fs_raw = run && (h == '0) && (v == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= 1'b0;
      h         <= '0;
      v         <= '0;
      xin       <= 1'b0;
      yin       <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      line_base <= '0;
      sub_x     <= '0;
      sub_y     <= '0;
    end else begin
      run   <= 1'b1;
      h     <= h_nxt;
      v     <= v_nxt;
      xin   <= xin_nxt;
      yin   <= yin_nxt;
      rd_en <= xin_nxt & yin_nxt;
      if (restart) begin
        rd_addr   <= '0;
        line_base <= '0;
        sub_x     <= '0;
        sub_y     <= '0;
      end else if (rd_en) begin
        // End of a window line: replay the same image row or step to the next
        if (h == WX_LAST) begin
          sub_x <= '0;
          if (sub_y == S_LAST) begin
            sub_y     <= '0;
            line_base <= line_base + IMG_W_A;
            rd_addr   <= line_base + IMG_W_A;
          end else begin
            sub_y   <= sub_y + 1'b1;
            rd_addr <= line_base;
          end
        end else if (sub_x == S_LAST) begin
          sub_x   <= '0;
          rd_addr <= rd_addr + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
    end
  end

  // Stage k holds the counter-state flags from k+1 clocks ago
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_p <= {PD{~HS_POL}};
      vs_p <= {PD{~VS_POL}};
      de_p <= '0;
      fs_p <= '0;
      wn_p <= '0;
      rgb  <= '0;
    end else begin
      hs_p <= {hs_p[PD-2:0], hs_raw};
      vs_p <= {vs_p[PD-2:0], vs_raw};
      de_p <= {de_p[PD-2:0], de_raw};
      fs_p <= {fs_p[PD-2:0], fs_raw};
      wn_p <= {wn_p[PD-2:0], rd_en};
      if (wn_p[PD-2])      rgb <= rd_data;
      else if (de_p[PD-2]) rgb <= BORDER;
      else                 rgb <= '0;
    end
  end

  assign hsync       = hs_p[PD-1];
  assign vsync       = vs_p[PD-1];
  assign de          = de_p[PD-1];
  assign frame_start = fs_p[PD-1];
  assign red         = rgb[CW-1:0];
  assign grn         = rgb[2*CW-1:CW];
  assign blu         = rgb[3*CW-1:2*CW];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: reduced timing, offset window, SCALE=2, RD_LAT=3,
// checked every clock against a position/arithmetic reference model.
module tb_vga_scan_gen;
  localparam int CW = 4, H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_ACTIVE = 30, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int IMG_W = 12, IMG_H = 8, SCALE = 2, WIN_X = 5, WIN_Y = 4;
  localparam int RD_LAT = 3, ADDR_W = 8, PD = RD_LAT + 1;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
  localparam logic [11:0] BORDER = 12'h00F;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic              clk = 1'b0;
  logic              rst, frame_sync;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data;
  logic [CW-1:0]     red, grn, blu;
  logic              hsync, vsync, de, frame_start;

  vga_scan_gen #(
    .CW(CW), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .SCALE(SCALE), .WIN_X(WIN_X), .WIN_Y(WIN_Y), .RD_LAT(RD_LAT),
    .ADDR_W(ADDR_W), .BORDER(BORDER)
  ) dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .red(red), .grn(grn), .blu(blu),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- frame memory model ----------------
  logic [11:0] mem [256];
  logic [11:0] mp  [RD_LAT];
  always @(posedge clk) begin
    mp[0] <= mem[rd_addr];
    for (int k = 1; k < RD_LAT; k++) mp[k] <= mp[k-1];
  end
  assign rd_data = mp[RD_LAT-1];

  int rden_cnt = 0, fs_cnt = 0;
  always @(posedge clk) begin
    if (rd_en)       rden_cnt <= rden_cnt + 1;
    if (frame_start) fs_cnt   <= fs_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit in_win(input int h, input int v);
    return h >= WIN_X && h < WIN_X + IMG_W * SCALE && v >= WIN_Y && v < WIN_Y + IMG_H * SCALE;
  endfunction

  function automatic int win_addr(input int h, input int v);
    return ((v - WIN_Y) / SCALE) * IMG_W + (h - WIN_X) / SCALE;
  endfunction

  // Expected {hsync, vsync, de, frame_start, blu, grn, red} for one position
  function automatic logic [15:0] pos_out(input bit run, input int h, input int v);
    logic hs, vs, d, fs;
    logic [11:0] rgb;
    hs = (run && h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
    vs = (run && v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
    d  = run && h < H_ACTIVE && v < V_ACTIVE;
    fs = run && h == 0 && v == 0;
    if (run && in_win(h, v)) rgb = mem[8'(win_addr(h, v))];
    else if (d)              rgb = BORDER;
    else                     rgb = 12'h000;
    return {hs, vs, d, fs, rgb};
  endfunction

  // Model position of the current counter state; exp_q holds outputs in flight
  bit m_run = 1'b0, m_rst = 1'b1;
  int mh = 0, mv = 0;
  logic [15:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_rst = 1'b1; m_run = 1'b0; mh = 0; mv = 0;
        exp_q = {};
        repeat (PD) exp_q.push_back(pos_out(1'b0, 0, 0));
      end else begin
        m_rst = 1'b0;
        exp_q.push_back(pos_out(m_run, mh, mv));
        void'(exp_q.pop_front());
        if (!m_run || frame_sync) begin
          mh = 0; mv = 0; m_run = 1'b1;
        end else if (mh == H_TOT - 1) begin
          mh = 0;
          mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      @(negedge clk);
      if (chk_en) begin
        check("rd_en", 32'(rd_en), 32'(m_run && in_win(mh, mv)));
        if (m_run && in_win(mh, mv)) check("rd_addr", 32'(rd_addr), 32'(win_addr(mh, mv)));
        if (m_rst) check("rst_addr", 32'(rd_addr), 32'd0);
        check("video", 32'({hsync, vsync, de, frame_start, blu, grn, red}), 32'(exp_q[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(m_run && mh == h && mv == v) && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos", 32'(m_run && mh == h && mv == v), 32'd1);
  endtask

  task automatic pulse_sync_at(input int h, input int v);
    wait_pos(h, v);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic frame_counts();
    int c0, f0;
    wait_pos(0, 0);
    c0 = rden_cnt;
    f0 = fs_cnt;
    run_cycles(FRAME);
    check("rden_per_frame", 32'(rden_cnt - c0), 32'(IMG_W * IMG_H * SCALE * SCALE));
    check("fs_per_frame", 32'(fs_cnt - f0), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    rst = 1'b1;
    frame_sync = 1'b0;
    run_cycles(3);
    chk_en = 1'b1;
    run_cycles(2);
    rst = 1'b0;

    run_cycles(2 * FRAME + 10);
    frame_counts();

    pulse_sync_at(20, 10);
    run_cycles(FRAME);

    pulse_sync_at(H_TOT - 1, V_TOT - 1);
    run_cycles(200);

    frame_sync = 1'b1;
    run_cycles(10);
    frame_sync = 1'b0;
    run_cycles(300);

    wait_pos(25, 8);
    rst = 1'b1;
    frame_sync = 1'b1;
    run_cycles(5);
    rst = 1'b0;
    frame_sync = 1'b0;
    run_cycles(FRAME + 100);

    for (int i = 0; i < 4; i++) begin
      pulse_sync_at($urandom_range(0, H_TOT - 1), $urandom_range(0, V_TOT - 1));
      run_cycles($urandom_range(50, 600));
    end

    for (int i = 0; i < 3000; i++) begin
      frame_sync = ($urandom_range(0, 299) == 0);
      rst        = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    frame_sync = 1'b0;

    run_cycles(10);
    frame_counts();
    run_cycles(PD + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
